// File: rtl/vga_sync_gen.sv
// ============================================================================
// Module   : vga_sync_gen
// Purpose  : 640x480@60Hz VGA timing source with pixel coordinates for the game
//            logic and registered, blanked RGB/HS/VS/blank_n outputs to the DAC.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_sync_gen #(
  parameter int                     CLK_DIV   = 2,
  parameter int                     H_VISIBLE = 640,
  parameter int                     H_FRONT   = 16,
  parameter int                     H_SYNC    = 96,
  parameter int                     H_BACK    = 48,
  parameter int                     V_VISIBLE = 480,
  parameter int                     V_FRONT   = 10,
  parameter int                     V_SYNC    = 2,
  parameter int                     V_BACK    = 33,
  parameter bit                     SYNC_POL  = 1'b0,
  parameter int                     COLOR_W   = 4,
  parameter logic [3*COLOR_W-1:0]   FG_COLOR  = 12'hFFF,
  parameter logic [3*COLOR_W-1:0]   BG_COLOR  = 12'h000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               color_in,
  output logic [9:0]         x,
  output logic [9:0]         y,
  output logic               pixel_tick,
  output logic               video_on,
  output logic               frame_start,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic [COLOR_W-1:0] vga_r,
  output logic [COLOR_W-1:0] vga_g,
  output logic [COLOR_W-1:0] vga_b,
  output logic               blank_n
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] c_DIV_LAST     = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       c_H_VIS        = 10'(H_VISIBLE);
  localparam logic [9:0]       c_H_SYNC_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0]       c_H_SYNC_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0]       c_H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0]       c_V_VIS        = 10'(V_VISIBLE);
  localparam logic [9:0]       c_V_SYNC_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]       c_V_SYNC_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0]       c_V_LAST       = 10'(V_TOTAL - 1);
  localparam logic             c_SYNC_ON      = SYNC_POL;
  localparam logic             c_SYNC_OFF     = ~SYNC_POL;

  logic [DIV_W-1:0]     r_div;
  logic [9:0]           r_h;
  logic [9:0]           r_v;
  logic                 r_hs;
  logic                 r_vs;
  logic                 r_blank;
  logic [3*COLOR_W-1:0] r_rgb;

  logic                 w_tick;
  logic                 w_h_last;
  logic                 w_v_last;
  logic                 w_hs_act;
  logic                 w_vs_act;
  logic                 w_von;
  logic [3*COLOR_W-1:0] w_pix;

  assign w_tick   = (r_div == c_DIV_LAST);
  assign w_h_last = (r_h == c_H_LAST);
  assign w_v_last = (r_v == c_V_LAST);
  assign w_hs_act = (r_h >= c_H_SYNC_START) && (r_h < c_H_SYNC_END);
  assign w_vs_act = (r_v >= c_V_SYNC_START) && (r_v < c_V_SYNC_END);
  assign w_von    = (r_h < c_H_VIS) && (r_v < c_V_VIS);
  assign w_pix    = w_von ? (color_in ? FG_COLOR : BG_COLOR) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Vertical counter steps only on the tick that wraps the horizontal one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_tick) begin
      r_h <= w_h_last ? 10'd0 : r_h + 10'd1;
      if (w_h_last) begin
        r_v <= w_v_last ? 10'd0 : r_v + 10'd1;
      end
    end
  end

  // Pin stage captures the pixel being left, so every pin carries the same one-pixel delay.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hs    <= c_SYNC_OFF;
      r_vs    <= c_SYNC_OFF;
      r_blank <= 1'b0;
      r_rgb   <= '0;
    end else if (w_tick) begin
      r_hs    <= w_hs_act ? c_SYNC_ON : c_SYNC_OFF;
      r_vs    <= w_vs_act ? c_SYNC_ON : c_SYNC_OFF;
      r_blank <= w_von;
      r_rgb   <= w_pix;
    end
  end

  assign x           = r_h;
  assign y           = r_v;
  assign pixel_tick  = w_tick;
  assign video_on    = w_von;
  assign frame_start = w_tick && w_h_last && w_v_last;
  assign vga_hs      = r_hs;
  assign vga_vs      = r_vs;
  assign blank_n     = r_blank;
  assign vga_r       = r_rgb[3*COLOR_W-1 -: COLOR_W];
  assign vga_g       = r_rgb[2*COLOR_W-1 -: COLOR_W];
  assign vga_b       = r_rgb[COLOR_W-1 -: COLOR_W];

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
// ============================================================================
// Module   : tb_vga_sync_gen
// Purpose  : Randomized bench comparing vga_sync_gen against an arithmetic
//            model of the raster (pixel index from clocks since reset).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_vga_sync_gen;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        tick;
    logic        von;
    logic        fs;
    logic        hs;
    logic        vs;
    logic        blank;
    logic [11:0] rgb;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic col_a = 1'b0;
  logic drv_col_b = 1'b0;
  logic game_mode = 1'b0;
  logic game_col = 1'b0;
  logic col_b;

  assign col_b = game_mode ? game_col : drv_col_b;

  always #5 clk = ~clk;

  logic [9:0] a_x, a_y, b_x, b_y;
  logic       a_tick, a_von, a_fs, a_hs, a_vs, a_blank;
  logic       b_tick, b_von, b_fs, b_hs, b_vs, b_blank;
  logic [3:0] a_r, a_g, a_b, b_r, b_g, b_b;

  vga_sync_gen dut_a (
    .clk(clk), .reset(reset), .color_in(col_a),
    .x(a_x), .y(a_y), .pixel_tick(a_tick), .video_on(a_von), .frame_start(a_fs),
    .vga_hs(a_hs), .vga_vs(a_vs), .vga_r(a_r), .vga_g(a_g), .vga_b(a_b), .blank_n(a_blank)
  );

  vga_sync_gen #(
    .CLK_DIV(3), .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_VISIBLE(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_POL(1'b1)
  ) dut_b (
    .clk(clk), .reset(reset), .color_in(col_b),
    .x(b_x), .y(b_y), .pixel_tick(b_tick), .video_on(b_von), .frame_start(b_fs),
    .vga_hs(b_hs), .vga_vs(b_vs), .vga_r(b_r), .vga_g(b_g), .vga_b(b_b), .blank_n(b_blank)
  );

  exp_t oa, ob;
  assign oa = {a_x, a_y, a_tick, a_von, a_fs, a_hs, a_vs, a_blank, a_r, a_g, a_b};
  assign ob = {b_x, b_y, b_tick, b_von, b_fs, b_hs, b_vs, b_blank, b_r, b_g, b_b};

  int checks = 0;
  int errors = 0;

  // Model state: clocks since reset release and color seen at the latest tick edge.
  int   ca, cb;
  logic mca, mcb;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ca  <= 0;
      cb  <= 0;
      mca <= 1'b0;
      mcb <= 1'b0;
    end else begin
      if (ca % 2 == 1) mca <= col_a;
      if (cb % 3 == 2) mcb <= col_b;
      ca <= ca + 1;
      cb <= cb + 1;
    end
  end

  // Game logic stand-in: registers a hit on one coordinate, one clk after x/y change.
  always @(posedge clk) game_col <= (b_x == 10'd5) && (b_y == 10'd3);

  function automatic exp_t model(input int c, input logic col, input int div,
                                 input int hv, input int hf, input int hsw, input int hb,
                                 input int vv, input int vf, input int vsw, input int vb,
                                 input logic pol);
    exp_t e;
    int ht, vt, n, q, px, py;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    n  = c / div;
    e.x    = 10'(n % ht);
    e.y    = 10'((n / ht) % vt);
    e.tick = ((c % div) == div - 1);
    e.von  = ((n % ht) < hv) && (((n / ht) % vt) < vv);
    e.fs   = e.tick && ((n % ht) == ht - 1) && (((n / ht) % vt) == vt - 1);
    if (n == 0) begin
      e.hs = ~pol; e.vs = ~pol; e.blank = 1'b0; e.rgb = 12'h000;
    end else begin
      q  = n - 1;
      px = q % ht;
      py = (q / ht) % vt;
      e.hs    = (px >= hv + hf && px < hv + hf + hsw) ? pol : ~pol;
      e.vs    = (py >= vv + vf && py < vv + vf + vsw) ? pol : ~pol;
      e.blank = (px < hv) && (py < vv);
      e.rgb   = e.blank ? (col ? 12'hFFF : 12'h000) : 12'h000;
    end
    return e;
  endfunction

  function automatic exp_t exp_a();
    return model(ca, mca, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
  endfunction

  function automatic exp_t exp_b();
    return model(cb, mcb, 3, 16, 2, 4, 3, 10, 2, 2, 3, 1'b1);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    col_a = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (a_x !== 10'd0 || a_y !== 10'd0) begin
      errors++; $display("FAIL reset_xy got x=%0d y=%0d want 0 0", a_x, a_y);
    end
    checks++;
    if (a_tick !== 1'b0 || a_fs !== 1'b0) begin
      errors++; $display("FAIL reset_tick_fs got tick=%b fs=%b want 0 0", a_tick, a_fs);
    end
    checks++;
    if (a_von !== 1'b1) begin
      errors++; $display("FAIL reset_video_on got %b want 1", a_von);
    end
    checks++;
    if (a_hs !== 1'b1 || a_vs !== 1'b1) begin
      errors++; $display("FAIL reset_sync_a got hs=%b vs=%b want 1 1", a_hs, a_vs);
    end
    checks++;
    if (b_hs !== 1'b0 || b_vs !== 1'b0) begin
      errors++; $display("FAIL reset_sync_b got hs=%b vs=%b want 0 0", b_hs, b_vs);
    end
    checks++;
    if ({a_r, a_g, a_b} !== 12'h000 || a_blank !== 1'b0) begin
      errors++; $display("FAIL reset_rgb got rgb=%h blank=%b want 000 0", {a_r, a_g, a_b}, a_blank);
    end
    col_a = 1'b0;
  endtask

  task automatic test_pixel_timing();
    exp_t e;
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      e = exp_a();
      checks++;
      if (oa !== e) begin
        errors++; $display("FAIL pixel_timing c=%0d got %h want %h", ca, oa, e);
      end
    end
  endtask

  task automatic test_line();
    exp_t e;
    int hs_clks = 0;
    for (int i = 0; i < 1700; i++) begin
      @(negedge clk);
      e = exp_a();
      checks++;
      if (oa !== e) begin
        errors++; $display("FAIL line c=%0d got %h want %h", ca, oa, e);
      end
      if (a_hs === 1'b0) hs_clks++;
      col_a = 1'($urandom);
    end
    checks++;
    if (hs_clks != 192) begin
      errors++; $display("FAIL hs_width got %0d clks want 192", hs_clks);
    end
  endtask

  task automatic test_color_const();
    exp_t e;
    int fff_clks = 0;
    col_a = 1'b1;
    for (int i = 0; i < 1700; i++) begin
      @(negedge clk);
      e = exp_a();
      checks++;
      if (oa !== e) begin
        errors++; $display("FAIL color_const c=%0d got %h want %h", ca, oa, e);
      end
      if ({a_r, a_g, a_b} === 12'hFFF) fff_clks++;
    end
    checks++;
    if (fff_clks < 2 * 640 || fff_clks > 2 * 2 * 640) begin
      errors++; $display("FAIL color_const_count got %0d clks want 1280..2560", fff_clks);
    end
  endtask

  task automatic test_frame();
    exp_t e;
    int fs_cnt = 0;
    int fs_c0 = 0;
    int fs_gap = 0;
    int vs_clks = 0;
    for (int i = 0; i < 2 * 1275 + 10; i++) begin
      @(negedge clk);
      e = exp_b();
      checks++;
      if (ob !== e) begin
        errors++; $display("FAIL frame c=%0d got %h want %h", cb, ob, e);
      end
      if (fs_cnt == 1 && b_vs === 1'b1) vs_clks++;
      if (b_fs === 1'b1) begin
        if (fs_cnt == 1) fs_gap = cb - fs_c0;
        fs_c0 = cb;
        fs_cnt++;
      end
      drv_col_b = 1'($urandom);
    end
    checks++;
    if (fs_cnt != 2 || fs_gap != 1275) begin
      errors++; $display("FAIL frame_start got count=%0d gap=%0d want 2 1275", fs_cnt, fs_gap);
    end
    checks++;
    if (vs_clks != 150) begin
      errors++; $display("FAIL vs_width got %0d clks want 150", vs_clks);
    end
  endtask

  task automatic test_game_pixel();
    exp_t e;
    int fff_clks = 0;
    game_mode = 1'b1;
    for (int i = 0; i < 1285; i++) begin
      @(negedge clk);
      e = exp_b();
      checks++;
      if (ob !== e) begin
        errors++; $display("FAIL game_pixel c=%0d got %h want %h", cb, ob, e);
      end
      if ({b_r, b_g, b_b} === 12'hFFF) fff_clks++;
    end
    checks++;
    if (fff_clks != 3) begin
      errors++; $display("FAIL game_pixel_count got %0d clks want 3", fff_clks);
    end
    game_mode = 1'b0;
  endtask

  task automatic test_reset_midframe();
    exp_t e;
    bit found = 1'b0;
    int hs_clks = 0;
    for (int i = 0; i < 1300 && !found; i++) begin
      @(negedge clk);
      e = exp_b();
      if (e.x == 10'd7 && e.y == 10'd5) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL midframe_reach got none want x=7 y=5");
    end
    reset = 1'b1;
    #1;
    checks++;
    if (b_x !== 10'd0 || b_y !== 10'd0 || a_x !== 10'd0 || a_y !== 10'd0) begin
      errors++; $display("FAIL async_reset_xy got b=%0d,%0d a=%0d,%0d want 0", b_x, b_y, a_x, a_y);
    end
    checks++;
    if (b_hs !== 1'b0 || b_vs !== 1'b0 || a_hs !== 1'b1 || a_vs !== 1'b1) begin
      errors++; $display("FAIL async_reset_sync got b=%b%b a=%b%b want 00 11", b_hs, b_vs, a_hs, a_vs);
    end
    checks++;
    if ({b_r, b_g, b_b} !== 12'h000 || b_blank !== 1'b0) begin
      errors++; $display("FAIL async_reset_rgb got %h blank=%b want 000 0", {b_r, b_g, b_b}, b_blank);
    end
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 85; i++) begin
      @(negedge clk);
      e = exp_b();
      checks++;
      if (ob !== e) begin
        errors++; $display("FAIL restart c=%0d got %h want %h", cb, ob, e);
      end
      if (b_hs === 1'b1) hs_clks++;
      drv_col_b = 1'($urandom);
    end
    checks++;
    if (hs_clks != 12) begin
      errors++; $display("FAIL hs_high_width got %0d clks want 12", hs_clks);
    end
  endtask

  initial begin
    test_reset();
    test_pixel_timing();
    test_line();
    test_color_const();
    test_frame();
    test_game_pixel();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
